// File: rtl/pc_gen_mw_pkg.sv
// Shared definitions for the multi-wide fetch-address generator:
// reset vector default, AdEL exception bit, FSM states and bus widths.
package pc_gen_mw_pkg;

   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned EXC_W         = 32;
   localparam int unsigned EXC_ADEL_BIT  = 16;
   localparam logic [ADDR_W-1:0] RESET_VEC_DEF = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      EXC_HOLD = 2'd2
   } pcgen_state_t;

endpackage

// File: rtl/pc_gen_mw_slot_mask.sv
// pc_slot_mask: decodes the in-group byte offset of the fetch address into
// the valid-slot mask and the misaligned-fetch (AdEL) flag.
module pc_slot_mask #(
   parameter int unsigned FETCH_W   = 2,
   parameter int unsigned SLOT_BITS = $clog2(FETCH_W)
) (
   input  logic [SLOT_BITS+1:0] off,
   input  logic                 valid,
   output logic [FETCH_W-1:0]   inst_mask,
   output logic                 adel
);

   int unsigned slot;

   always_comb begin
      inst_mask = '0;
      adel      = 1'b0;
      slot      = 32'(off) >> 2;
      if (valid) begin
         adel = |off[1:0];
         // A misaligned fetch only exposes the word that contains it.
         for (int unsigned i = 0; i < FETCH_W; i++) begin
            inst_mask[i] = adel ? (i == slot) : (i >= slot);
         end
      end
   end

endmodule

// File: rtl/pc_gen_mw.sv
// Multi-wide fetch-address generator with valid/ready handshake to the I-cache.
// Define PCGEN_BP_EN to let bp_e/bp_target redirect accepted groups.
module pc_gen_mw
   import pc_gen_mw_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
   parameter int unsigned FETCH_W   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [31:0]        new_pc,
   input  logic               br_e,
   input  logic [31:0]        br_target,
   input  logic               bp_e,
   input  logic [31:0]        bp_target,
   input  logic               ic_ready,
   output logic               pc_valid,
   output logic [31:0]        pc,
   output logic [FETCH_W-1:0] inst_mask,
   output logic [31:0]        excepttype
);

   localparam int unsigned SLOT_BITS = $clog2(FETCH_W);
   localparam logic [31:0] GRP_BYTES = 32'(4 * FETCH_W);

   pcgen_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d, seq;
   logic         accept, adel;

`ifndef PCGEN_BP_EN
   logic unused_bp;
   assign unused_bp = ^{bp_e, bp_target};
`endif

   pc_slot_mask #(.FETCH_W(FETCH_W)) u_slot_mask (
      .off       (pc_q[SLOT_BITS+1:0]),
      .valid     (pc_valid),
      .inst_mask (inst_mask),
      .adel      (adel)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_VEC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_valid   = (state_q == RUN);
      pc         = pc_q;
      excepttype = '0;
      excepttype[EXC_ADEL_BIT] = adel;
      accept     = pc_valid & ic_ready;
      seq        = (pc_q & ~(GRP_BYTES - 32'd1)) + GRP_BYTES;

      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (flush) begin
               pc_d = new_pc;
            end else if (br_e) begin
               pc_d = br_target;
            end else if (accept && adel) begin
               state_d = EXC_HOLD;
`ifdef PCGEN_BP_EN
            end else if (accept && bp_e) begin
               pc_d = bp_target;
`endif
            end else if (accept) begin
               pc_d = seq;
            end
         end
         EXC_HOLD: begin
            if (flush) begin
               state_d = RUN;
               pc_d    = new_pc;
            end else if (br_e) begin
               state_d = RUN;
               pc_d    = br_target;
            end
         end
         default: state_d = BOOT;
      endcase
   end

endmodule
